// File: rtl/ofm_write_serializer.sv
// ofm_write_serializer
//   Buffers packed systolic output rows in a small FIFO and writes them to the
//   OFM memory one element per cycle, at consecutive (wrapping) addresses.
//
// Ports
//   clk        : clock, all state changes on its rising edge
//   rst        : asynchronous active-high reset
//   row_valid  : upstream offers a row
//   row_ready  : a FIFO slot is free (registered from occupancy)
//   row_data   : packed row, element i at [i*DATA_WIDTH +: DATA_WIDTH]
//   row_addr   : OFM address of element 0
//   row_size   : number of valid elements (clamped to SYSTOLIC_SIZE)
//   ofm_we     : OFM write enable
//   ofm_waddr  : OFM write address (holds when ofm_we is low)
//   ofm_wdata  : OFM write data (holds when ofm_we is low)
//   row_done   : one-cycle pulse on a row's last write or on a discarded empty row
//   busy       : FIFO non-empty or a row is being written
module ofm_write_serializer #(
  parameter int SYSTOLIC_SIZE = 16,
  parameter int DATA_WIDTH    = 16,
  parameter int ADDR_WIDTH    = 14,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                row_valid,
  output logic                                row_ready,
  input  logic [SYSTOLIC_SIZE*DATA_WIDTH-1:0] row_data,
  input  logic [ADDR_WIDTH-1:0]               row_addr,
  input  logic [4:0]                          row_size,
  output logic                                ofm_we,
  output logic [ADDR_WIDTH-1:0]               ofm_waddr,
  output logic [DATA_WIDTH-1:0]               ofm_wdata,
  output logic                                row_done,
  output logic                                busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int RW = SYSTOLIC_SIZE * DATA_WIDTH;

  typedef enum logic {S_IDLE, S_WRITE} state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
  logic                    ready_q;

  logic [RW-1:0]           fifo_data_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]   fifo_addr_q [FIFO_DEPTH];
  logic [4:0]              fifo_size_q [FIFO_DEPTH];

  logic [RW-1:0]           work_data_q;
  logic [ADDR_WIDTH-1:0]   work_addr_q;
  logic [4:0]              work_size_q;
  logic [4:0]              idx_q, idx_d;

  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    done_q, done_d;

  logic                    push, pop, fifo_empty;
  logic [4:0]              size_clamped;

  assign fifo_empty   = (cnt_q == '0);
  assign push         = row_valid && ready_q;
  assign size_clamped = (row_size > 5'(SYSTOLIC_SIZE)) ? 5'(SYSTOLIC_SIZE) : row_size;

  assign row_ready = ready_q;
  assign ofm_we    = we_q;
  assign ofm_waddr = waddr_q;
  assign ofm_wdata = wdata_q;
  assign row_done  = done_q;
  assign busy      = !fifo_empty || (state_q != S_IDLE);

  // FIFO storage carries no reset; occupancy is tracked by cnt_q/pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= row_data;
      fifo_addr_q[wr_ptr_q] <= row_addr;
      fifo_size_q[wr_ptr_q] <= size_clamped;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // A pop never coincides with a push into a full FIFO: ready reflects the
  // occupancy at the previous edge, so a pop cannot free a slot for the same
  // cycle's push.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          idx_d   = '0;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (work_size_q != '0) begin
          we_d    = 1'b1;
          waddr_d = work_addr_q + ADDR_WIDTH'(idx_q);
          wdata_d = work_data_q[idx_q*DATA_WIDTH +: DATA_WIDTH];
        end
        // Last element (or empty row): load the next entry in the same edge so
        // back-to-back rows stream without a bubble.
        if ((work_size_q == '0) || (idx_q == work_size_q - 5'd1)) begin
          done_d = 1'b1;
          idx_d  = '0;
          if (!fifo_empty) begin
            pop = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          idx_d = idx_q + 5'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ready_q     <= 1'b0;
      work_data_q <= '0;
      work_addr_q <= '0;
      work_size_q <= '0;
      idx_q       <= '0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ready_q  <= (cnt_d != CW'(FIFO_DEPTH));
      idx_q    <= idx_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      done_q   <= done_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q    <= rd_ptr_q + PW'(1);
        work_data_q <= fifo_data_q[rd_ptr_q];
        work_addr_q <= fifo_addr_q[rd_ptr_q];
        work_size_q <= fifo_size_q[rd_ptr_q];
      end
    end
  end

endmodule

// File: tb/tb_ofm_write_serializer.sv
module tb_ofm_write_serializer;

  localparam int SS = 16;
  localparam int DW = 16;
  localparam int AW = 14;

  logic               clk = 1'b0;
  logic               rst;
  logic               row_valid;
  logic               row_ready;
  logic [SS*DW-1:0]   row_data;
  logic [AW-1:0]      row_addr;
  logic [4:0]         row_size;
  logic               ofm_we;
  logic [AW-1:0]      ofm_waddr;
  logic [DW-1:0]      ofm_wdata;
  logic               row_done;
  logic               busy;

  ofm_write_serializer #(
    .SYSTOLIC_SIZE(SS),
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .row_valid(row_valid), .row_ready(row_ready),
    .row_data(row_data), .row_addr(row_addr), .row_size(row_size),
    .ofm_we(ofm_we), .ofm_waddr(ofm_waddr), .ofm_wdata(ofm_wdata),
    .row_done(row_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Expected output stream: one event per element write, or one done-only
  // event for an empty row, in acceptance order.
  typedef struct {
    bit            zero;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit            last;
  } ev_t;

  ev_t           q[$];
  int            total = 0;
  int            bad   = 0;
  int            n_we  = 0;
  int            n_done = 0;
  int            n_acc = 0;
  bit            last_acc;
  bit            saw_low;
  int            acc_when_low;
  logic [AW-1:0] hold_a;
  logic [DW-1:0] hold_d;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_push(input logic [AW-1:0] a, input logic [4:0] sz, input logic [SS*DW-1:0] d);
    int n;
    ev_t e;
    logic [SS*DW-1:0] dd;
    dd = d;
    n = (int'(sz) > SS) ? SS : int'(sz);
    if (n == 0) begin
      e.zero = 1'b1; e.a = '0; e.d = '0; e.last = 1'b1;
      q.push_back(e);
    end
    for (int i = 0; i < n; i++) begin
      e.zero = 1'b0;
      e.a    = AW'((int'(a) + i) % (1 << AW));
      e.d    = dd[i*DW +: DW];
      e.last = (i == n - 1);
      q.push_back(e);
    end
  endtask

  task automatic observe();
    ev_t e;
    if (ofm_we === 1'b1) begin
      n_we++;
      if (row_done === 1'b1) n_done++;
      if (q.size() == 0) begin
        check("we_unexpected", 32'(ofm_we), 32'd0);
      end else begin
        e = q.pop_front();
        check("we_on_empty_row", 32'(ofm_we), 32'(!e.zero));
        check("waddr", 32'(ofm_waddr), 32'(e.a));
        check("wdata", 32'(ofm_wdata), 32'(e.d));
        check("done_on_write", 32'(row_done), 32'(e.last));
        hold_a = e.a;
        hold_d = e.d;
      end
    end else begin
      check("hold_waddr", 32'(ofm_waddr), 32'(hold_a));
      check("hold_wdata", 32'(ofm_wdata), 32'(hold_d));
      if (row_done === 1'b1) begin
        n_done++;
        if (q.size() == 0) begin
          check("done_unexpected", 32'(row_done), 32'd0);
        end else begin
          e = q.pop_front();
          check("done_without_write", 32'(row_done), 32'(e.zero));
        end
      end
    end
  endtask

  task automatic cyc();
    bit acc;
    acc = (row_valid === 1'b1) && (row_ready === 1'b1);
    @(posedge clk);
    if (acc) begin
      model_push(row_addr, row_size, row_data);
      n_acc++;
    end
    last_acc = acc;
    #1;
    if (row_ready === 1'b0 && !saw_low) begin
      saw_low      = 1'b1;
      acc_when_low = n_acc;
    end
    observe();
  endtask

  task automatic send(input logic [AW-1:0] a, input logic [4:0] sz, input logic [SS*DW-1:0] d);
    row_addr  = a;
    row_size  = sz;
    row_data  = d;
    row_valid = 1'b1;
    last_acc  = 1'b0;
    for (int i = 0; i < 60; i++) begin
      cyc();
      if (last_acc) break;
    end
    check("accepted", 32'(last_acc), 32'd1);
  endtask

  task automatic drain(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (q.size() == 0 && busy === 1'b0 && ofm_we === 1'b0 && row_done === 1'b0) break;
      cyc();
    end
    check("drain_model_empty", 32'(q.size()), 32'd0);
    check("drain_busy", 32'(busy), 32'd0);
  endtask

  function automatic logic [SS*DW-1:0] rand_row();
    logic [SS*DW-1:0] r;
    for (int i = 0; i < SS; i++) r[i*DW +: DW] = DW'($urandom);
    return r;
  endfunction

  initial begin
    logic [SS*DW-1:0] d;
    int base_we, base_done;

    rst = 1'b1; row_valid = 1'b0; row_data = '0; row_addr = '0; row_size = '0;
    hold_a = '0; hold_d = '0; saw_low = 1'b0; acc_when_low = 0;
    #12;
    check("rst_we", 32'(ofm_we), 32'd0);
    check("rst_ready", 32'(row_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(row_done), 32'd0);
    check("rst_waddr", 32'(ofm_waddr), 32'd0);
    check("rst_wdata", 32'(ofm_wdata), 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("ready_before_edge", 32'(row_ready), 32'd0);
    cyc();
    check("ready_after_release", 32'(row_ready), 32'd1);

    // One full row, fixed pattern, latency and streaming
    for (int i = 0; i < SS; i++) d[i*DW +: DW] = DW'(i + 1);
    base_done = n_done;
    send(AW'('h0100), 5'd16, d);
    row_valid = 1'b0;
    cyc();
    check("lat_T1_we", 32'(ofm_we), 32'd0);
    for (int i = 0; i < 16; i++) begin
      cyc();
      check("row16_we", 32'(ofm_we), 32'd1);
    end
    cyc();
    check("row16_after_we", 32'(ofm_we), 32'd0);
    check("row16_done_cnt", 32'(n_done - base_done), 32'd1);
    drain(40);

    // Back-to-back rows with no gap
    base_done = n_done;
    send(AW'('h0000), 5'd8, rand_row());
    send(AW'('h0400), 5'd5, rand_row());
    row_valid = 1'b0;
    for (int i = 0; i < 13; i++) begin
      cyc();
      check("b2b_we", 32'(ofm_we), 32'd1);
    end
    cyc();
    check("b2b_end_we", 32'(ofm_we), 32'd0);
    check("b2b_done_cnt", 32'(n_done - base_done), 32'd2);
    drain(40);

    // Six rows with valid held high: FIFO fills, all written in order
    saw_low = 1'b0;
    n_acc   = 0;
    base_we = n_we;
    for (int r = 0; r < 6; r++) send(AW'($urandom), 5'd16, rand_row());
    row_valid = 1'b0;
    check("fill_ready_low", 32'(saw_low), 32'd1);
    check("fill_low_after_4", 32'(acc_when_low >= 4), 32'd1);
    drain(200);
    check("fill_writes", 32'(n_we - base_we), 32'd96);

    // Empty row, then oversize row wrapping the address space
    base_we = n_we; base_done = n_done;
    send(AW'('h0050), 5'd0, rand_row());
    send(AW'('h3FFE), 5'd20, rand_row());
    row_valid = 1'b0;
    drain(60);
    check("clamp_writes", 32'(n_we - base_we), 32'd16);
    check("clamp_done_cnt", 32'(n_done - base_done), 32'd2);

    // Reset in the middle of a row with two rows queued
    base_we = n_we;
    send(AW'($urandom), 5'd16, rand_row());
    send(AW'($urandom), 5'd7, rand_row());
    send(AW'($urandom), 5'd9, rand_row());
    row_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (n_we - base_we >= 3) break;
      cyc();
    end
    check("pre_rst_writes", 32'(n_we - base_we), 32'd3);
    rst = 1'b1;
    #1;
    check("midrst_we", 32'(ofm_we), 32'd0);
    check("midrst_ready", 32'(row_ready), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(row_done), 32'd0);
    q.delete();
    hold_a = '0; hold_d = '0;
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b0;
    base_we = n_we;
    for (int i = 0; i < 20; i++) cyc();
    check("post_rst_no_writes", 32'(n_we - base_we), 32'd0);
    send(AW'('h1234), 5'd12, rand_row());
    row_valid = 1'b0;
    drain(60);
    check("post_rst_row_writes", 32'(n_we - base_we), 32'd12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/ofm_write_serializer.md
OFM_WRITE_SERIALIZER -- requirements
Module: ofm_write_serializer

Interface
REQ-001 SHALL have parameter SYSTOLIC_SIZE, default 16: elements per systolic output row.
REQ-002 SHALL have parameter DATA_WIDTH, default 16: bits per OFM element.
REQ-003 SHALL have parameter ADDR_WIDTH, default 14: OFM memory address width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4: row entries buffered, power of two, at least 2.
REQ-005 SHALL have port clk  input  1: the only clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1: reset, asynchronous and active-high.
REQ-007 SHALL have port row_valid  input  1: an upstream row is offered.
REQ-008 SHALL have port row_ready  output  1: this block can accept a row.
REQ-009 SHALL have port row_data  input  SYSTOLIC_SIZE*DATA_WIDTH: packed row; element i in bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 SHALL have port row_addr  input  ADDR_WIDTH: OFM address of element 0, driven from the OFM address controller's ofm_addr.
REQ-011 SHALL have port row_size  input  5: number of valid elements, driven from the controller's ofm_size.
REQ-012 SHALL have port ofm_we  output  1: OFM memory write enable.
REQ-013 SHALL have port ofm_waddr  output  ADDR_WIDTH: OFM write address.
REQ-014 SHALL have port ofm_wdata  output  DATA_WIDTH: OFM write data.
REQ-015 SHALL have port row_done  output  1: one-cycle pulse when a row's last write is issued, or when a zero-size row is discarded.
REQ-016 SHALL have port busy  output  1: high while the FIFO is non-empty or the FSM is not in IDLE.

Function
REQ-017 SHALL accept a row on any rising edge where row_valid and row_ready are both high, pushing {row_data, row_addr, clamped row_size} into the FIFO.
REQ-018 SHALL drive row_ready = !fifo_full, registered from FIFO occupancy; a same-cycle pop SHALL NOT free a slot for that cycle's push.
REQ-019 SHALL clamp a row_size greater than SYSTOLIC_SIZE to SYSTOLIC_SIZE at push time.
REQ-020 SHALL implement FSM states IDLE and WRITE.
REQ-021 In IDLE with the FIFO non-empty, the FSM SHALL pop the head entry into a working register and move to WRITE; write index = 0.
REQ-022 In WRITE, the block SHALL register ofm_we=1, ofm_waddr = entry_addr + index (mod 2^ADDR_WIDTH), and ofm_wdata = element[index] each cycle, then increment index.
REQ-023 On the write with index == size-1, the block SHALL pulse row_done. The next state SHALL be WRITE with the next entry popped (no bubble) if the FIFO is non-empty; otherwise the next state SHALL be IDLE.
REQ-024 A popped entry with size 0 SHALL cause no write, SHALL pulse row_done for one cycle, and SHALL then follow the same next-entry rule.
REQ-025 Latency: for a row accepted at edge T into an empty, idle block, the first ofm_we SHALL be high in the cycle starting at edge T+2.
REQ-026 Throughput: rows SHALL be written strictly in acceptance order with exactly one element per cycle and no idle cycles between back-to-back non-empty rows.
REQ-027 ofm_we SHALL be 0 in every cycle not covered by REQ-022; ofm_waddr and ofm_wdata SHALL hold their last values when ofm_we=0.

Reset
REQ-028 Asserting rst SHALL immediately force: FSM=IDLE, FIFO empty, index=0, ofm_we=0, ofm_waddr=0, ofm_wdata=0, row_done=0, busy=0, row_ready=0.
REQ-029 row_ready SHALL rise on the first clock edge after rst deasserts.
REQ-030 Asserting rst mid-row SHALL abandon the in-flight and buffered rows; no further writes from them SHALL occur after reset is released.

Verification
REQ-031 One row (addr 0x0100, size 16, element i = i+1) -> 16 consecutive writes to 0x0100..0x010F with data 1..16, starting at T+2; row_done in the last write cycle.
REQ-032 Back-to-back rows (size 8 @0x0000, then size 5 @0x0400) -> 13 contiguous write cycles with no gap; row_done pulses twice.
REQ-033 Hold row_valid high for 6 rows with the sink idle -> row_ready low after 4 rows are accepted; all 6 rows are written in order.
REQ-034 size 0 at 0x0050, then size 20 at 0x3FFE -> zero-size row produces no write and one row_done; next row is clamped to 16 writes, addresses 0x3FFE, 0x3FFF, then wrapping to 0x0000..0x000D.
REQ-035 Assert rst after the 3rd write of a size-16 row while 2 rows are queued -> ofm_we=0 immediately; no writes after release; a new row is then written correctly.
